// File: rtl/fifo_rdbuf.sv
// Circular output buffer for the FIFO read stream: one push port, one pop port,
// occupancy count and head-of-queue data. DEPTH need not be a power of two.
module fifo_rdbuf #(
   parameter  int DWIDTH = 32,
   parameter  int DEPTH  = 3,
   localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int OCCW   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [OCCW-1:0]   occ,
   output logic [DWIDTH-1:0] head_data
);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   // Compare-and-clear wrap keeps pointers inside 0..DEPTH-1.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rdstream.sv
// Read-side engine for the external-memory FIFO: issues fiford, captures memdata
// after RDLAT cycles and presents the words as a valid/ready stream.
module fifo_rdstream #(
   parameter  int DWIDTH = 32,
   parameter  int RDLAT  = 1,
   parameter  int CNTBIT = 16,
   localparam int DEPTH  = RDLAT + 2,
   localparam int OCCW   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              notempty,
   output logic              fiford,
   input  logic [DWIDTH-1:0] memdata,
   output logic              out_vld,
   output logic [DWIDTH-1:0] out_data,
   input  logic              out_rdy,
   output logic [OCCW-1:0]   bufocc,
   output logic [CNTBIT-1:0] dcnt
);

   // Stream handshake: a word transfers in every cycle where out_vld and out_rdy
   // are both high; out_vld never waits on out_rdy, and out_data is held while
   // out_vld is high and out_rdy is low.
   localparam int SW = OCCW + 1;

   logic [RDLAT-1:0] inflt;
   logic [SW-1:0]    ninfl;
   logic [SW-1:0]    committed;
   logic             arr;
   logic             pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         inflt <= '0;
      end else begin
         inflt[0] <= fiford;
         for (int i = 1; i < RDLAT; i++) inflt[i] <= inflt[i-1];
      end
   end

   always_comb begin
      ninfl = '0;
      for (int i = 0; i < RDLAT; i++) ninfl = ninfl + SW'(inflt[i]);
   end

   // Reserve a buffer slot for every word in flight so no arrival is dropped;
   // out_rdy is deliberately absent to keep the issue path registered.
   assign committed = SW'(bufocc) + ninfl;
   assign fiford    = !rst && notempty && (committed < SW'(DEPTH));
   assign arr       = inflt[RDLAT-1];
   assign out_vld   = (bufocc != '0);
   assign pop       = out_vld && out_rdy;

   fifo_rdbuf #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (arr),
      .push_data (memdata),
      .pop       (pop),
      .occ       (bufocc),
      .head_data (out_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         dcnt <= '0;
      end else if (pop && (dcnt != {CNTBIT{1'b1}})) begin
         dcnt <= dcnt + 1'b1;
      end
   end

endmodule
